// File: rtl/vip_osd_capture_if.sv
// DVP input and bitmap RAM write port for vip_osd_capture.
// slave: capture block side; master: source/RAM side.
interface vip_osd_capture_if #(
  parameter int BITS          = 8,
  parameter int RAM_ADDR_BITS = 9,
  parameter int RAM_DATA_BITS = 32
);
  logic                     in_href;
  logic                     in_vsync;
  logic [BITS-1:0]          in_data;
  logic                     ram_wen;
  logic [RAM_ADDR_BITS-1:0] ram_addr;
  logic [RAM_DATA_BITS-1:0] ram_wdata;

  modport slave (
    input  in_href,
    input  in_vsync,
    input  in_data,
    output ram_wen,
    output ram_addr,
    output ram_wdata
  );

  modport master (
    output in_href,
    output in_vsync,
    output in_data,
    input  ram_wen,
    input  ram_addr,
    input  ram_wdata
  );
endinterface

// File: rtl/vip_osd_capture.sv
// Thresholds a DVP luma window into a 1-bpp bitmap, word-packed into OSD RAM.
// Ports: pclk/rst, window+threshold config, bus (DVP in, RAM write), frame_done, overflow.
module vip_osd_capture #(
  parameter int BITS          = 8,
  parameter int WIDTH         = 1280,
  parameter int HEIGHT        = 720,
  parameter int RAM_ADDR_BITS = 9,
  parameter int RAM_DATA_BITS = 32
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            cap_en,
  input  logic [10:0]     win_x,
  input  logic [9:0]      win_y,
  input  logic [10:0]     win_w,
  input  logic [9:0]      win_h,
  input  logic [BITS-1:0] threshold,
  vip_osd_capture_if.slave bus,
  output logic            frame_done,
  output logic            overflow
);

  localparam int A  = RAM_ADDR_BITS;
  localparam int D  = RAM_DATA_BITS;
  localparam int IW = $clog2(D);
  localparam int CW = IW + 1;

  logic            href_q, href_p;
  logic            vsync_q, vsync_p;
  logic [BITS-1:0] data_q;

  logic            cap_q;
  logic [10:0]     wx_q, ww_q;
  logic [9:0]      wy_q, wh_q;
  logic [BITS-1:0] thr_q;

  logic [11:0]     px;
  logic [10:0]     ln;
  logic [D-1:0]    pack;
  logic [CW-1:0]   cnt;
  logic [A:0]      nxt;

  logic            vs_rise, vs_fall, h_fall;
  logic [11:0]     x_end;
  logic [10:0]     y_end;
  logic            in_x, in_y, hit, bit_v, last;
  logic [IW-1:0]   idx;
  logic [D-1:0]    pack_n;
  logic [CW-1:0]   cnt_n;
  logic            word_full, pix_wr, flush, wr_req;
  logic [D-1:0]    wr_data;

  assign vs_rise = vsync_q & ~vsync_p;
  assign vs_fall = ~vsync_q & vsync_p;
  assign h_fall  = ~href_q & href_p;

  // One bit wider so window edges never wrap.
  assign x_end = {1'b0, wx_q} + {1'b0, ww_q};
  assign y_end = {1'b0, wy_q} + {1'b0, wh_q};

  assign in_x = (px >= {1'b0, wx_q}) && (px < x_end)
             && (px < 12'(WIDTH));
  assign in_y = (ln >= {1'b0, wy_q}) && (ln < y_end)
             && (ln < 11'(HEIGHT));
  assign hit   = cap_q & href_q & in_x & in_y;
  assign bit_v = data_q >= thr_q;
  assign last  = px == (x_end - 12'd1);

  // MSB-first: the n-th bit of a word lands at D-1-n.
  assign idx   = ~cnt[IW-1:0];
  assign cnt_n = cnt + CW'(1);

  always_comb begin
    pack_n      = pack;
    pack_n[idx] = bit_v;
  end

  assign word_full = cnt_n == CW'(D);
  assign pix_wr    = hit & (word_full | last);
  assign flush     = h_fall & (cnt != '0);
  assign wr_req    = pix_wr | flush;
  assign wr_data   = flush ? pack : pack_n;

  always_ff @(posedge pclk) begin
    if (rst) begin
      href_q        <= 1'b0;
      href_p        <= 1'b0;
      vsync_q       <= 1'b0;
      vsync_p       <= 1'b0;
      data_q        <= '0;
      cap_q         <= 1'b0;
      wx_q          <= '0;
      wy_q          <= '0;
      ww_q          <= '0;
      wh_q          <= '0;
      thr_q         <= '0;
      px            <= '0;
      ln            <= '0;
      pack          <= '0;
      cnt           <= '0;
      nxt           <= '0;
      bus.ram_wen   <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      frame_done    <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      href_q      <= bus.in_href;
      vsync_q     <= bus.in_vsync;
      data_q      <= bus.in_data;
      href_p      <= href_q;
      vsync_p     <= vsync_q;
      bus.ram_wen <= 1'b0;
      frame_done  <= 1'b0;
      if (vs_rise) begin
        // New frame: snapshot config, drop any pending word.
        cap_q        <= cap_en;
        wx_q         <= win_x;
        wy_q         <= win_y;
        ww_q         <= win_w;
        wh_q         <= win_h;
        thr_q        <= threshold;
        px           <= '0;
        ln           <= '0;
        pack         <= '0;
        cnt          <= '0;
        nxt          <= '0;
        bus.ram_addr <= '0;
        overflow     <= 1'b0;
      end else begin
        frame_done <= vs_fall & cap_q;
        if (href_q) begin
          px <= px + 12'd1;
        end else if (h_fall) begin
          px <= '0;
          ln <= ln + 11'd1;
        end
        if (hit) begin
          pack <= pix_wr ? '0 : pack_n;
          cnt  <= pix_wr ? '0 : cnt_n;
        end else if (flush) begin
          pack <= '0;
          cnt  <= '0;
        end
        if (wr_req) begin
          // nxt MSB set: RAM already full this frame.
          if (nxt[A]) begin
            overflow <= 1'b1;
          end else begin
            bus.ram_wen   <= 1'b1;
            bus.ram_addr  <= nxt[A-1:0];
            bus.ram_wdata <= wr_data;
            nxt           <= nxt + 1'b1;
          end
        end else if (bus.ram_wen && !nxt[A]) begin
          bus.ram_addr <= nxt[A-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_vip_osd_capture.sv
// Directed self-checking bench for vip_osd_capture.
// Drives DVP frames, logs RAM writes, checks against hand-computed words.
module tb_vip_osd_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        cap_en;
  logic [10:0] win_x, win_w;
  logic [9:0]  win_y, win_h;
  logic [7:0]  threshold;
  logic        frame_done, overflow;

  int n_chk  = 0;
  int n_pass = 0;
  int nfd    = 0;
  logic [8:0]  wa[$];
  logic [31:0] wd[$];

  vip_osd_capture_if bus ();

  vip_osd_capture dut (
    .pclk       (clk),
    .rst        (rst),
    .cap_en     (cap_en),
    .win_x      (win_x),
    .win_y      (win_y),
    .win_w      (win_w),
    .win_h      (win_h),
    .threshold  (threshold),
    .bus        (bus),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.ram_wen) begin
      wa.push_back(bus.ram_addr);
      wd.push_back(bus.ram_wdata);
    end
    if (frame_done) nfd++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
  endtask

  task automatic cfg(input logic en,
                     input int x, input int y,
                     input int w, input int h,
                     input int thr);
    cap_en    = en;
    win_x     = 11'(x);
    win_y     = 10'(y);
    win_w     = 11'(w);
    win_h     = 10'(h);
    threshold = 8'(thr);
    wa.delete();
    wd.delete();
    nfd = 0;
  endtask

  // mode 0: 0xFF for px<64 else 0; mode 1: all 0xFF
  function automatic logic [7:0] pix(input int mode,
                                     input int p);
    if (mode == 0) return (p < 64) ? 8'hFF : 8'h00;
    return 8'hFF;
  endfunction

  task automatic line(input int ppl, input int mode);
    for (int p = 0; p < ppl; p++) begin
      bus.in_href = 1'b1;
      bus.in_data = pix(mode, p);
      tick();
    end
    bus.in_href = 1'b0;
    bus.in_data = 8'h00;
    repeat (4) tick();
  endtask

  task automatic frame(input int lines, input int ppl,
                       input int mode);
    bus.in_vsync = 1'b1;
    repeat (3) tick();
    for (int l = 0; l < lines; l++) line(ppl, mode);
    repeat (3) tick();
    bus.in_vsync = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    int bad;
    rst          = 1'b1;
    bus.in_href  = 1'b0;
    bus.in_vsync = 1'b0;
    bus.in_data  = 8'h00;
    cfg(1'b0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_wen",   32'(bus.ram_wen),   0);
    chk("rst_addr",  32'(bus.ram_addr),  0);
    chk("rst_wdata", bus.ram_wdata,      0);
    chk("rst_fd",    32'(frame_done),    0);
    chk("rst_ovf",   32'(overflow),      0);
    rst = 1'b0;
    repeat (2) tick();

    // Basic: 128x32, left half white
    cfg(1'b1, 0, 0, 128, 32, 8'h80);
    frame(32, 128, 0);
    chk("basic_n", wa.size(), 128);
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      if (wa[i] !== 9'(i)) bad++;
      if (wd[i] !== (((i % 4) < 2) ? 32'hFFFFFFFF : 32'h0))
        bad++;
    end
    chk("basic_words", bad, 0);
    chk("basic_w1",  wd[1], 32'hFFFFFFFF);
    chk("basic_w2",  wd[2], 32'h00000000);
    chk("basic_fd",  nfd, 1);

    // Partial word
    cfg(1'b1, 0, 0, 40, 2, 8'h80);
    frame(2, 40, 1);
    chk("part_n",  wa.size(), 4);
    chk("part_d0", wd[0], 32'hFFFFFFFF);
    chk("part_d1", wd[1], 32'hFF000000);
    chk("part_d2", wd[2], 32'hFFFFFFFF);
    chk("part_d3", wd[3], 32'hFF000000);
    chk("part_a3", 32'(wa[3]), 3);

    // Right-edge clip, flush on href fall
    cfg(1'b1, 1264, 0, 128, 1, 8'h80);
    bus.in_vsync = 1'b1;
    repeat (3) tick();
    for (int p = 0; p < 1280; p++) begin
      bus.in_href = 1'b1;
      bus.in_data = 8'hFF;
      tick();
    end
    bus.in_href = 1'b0;
    bus.in_data = 8'h00;
    chk("clip_early", 32'(bus.ram_wen), 0);
    tick();
    chk("clip_early2", 32'(bus.ram_wen), 0);
    tick();
    chk("clip_wen",  32'(bus.ram_wen), 1);
    chk("clip_data", bus.ram_wdata, 32'hFFFF0000);
    chk("clip_addr", 32'(bus.ram_addr), 0);
    repeat (4) tick();
    bus.in_vsync = 1'b0;
    repeat (6) tick();
    chk("clip_n",  wa.size(), 1);
    chk("clip_fd", nfd, 1);

    // Empty window
    cfg(1'b1, 0, 0, 0, 32, 8'h80);
    frame(4, 64, 1);
    chk("empty_n",  wa.size(), 0);
    chk("empty_fd", nfd, 1);

    // Capture disabled
    cfg(1'b0, 0, 0, 64, 4, 8'h80);
    frame(4, 64, 1);
    chk("off_n",  wa.size(), 0);
    chk("off_fd", nfd, 0);

    // Overflow: 40 words/row x 32 rows > 512
    cfg(1'b1, 0, 0, 1280, 32, 8'h80);
    frame(32, 1280, 1);
    chk("ovf_n",    wa.size(), 512);
    chk("ovf_last", 32'(wa[511]), 511);
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (wa[i] !== 9'(i)) bad++;
    chk("ovf_seq",  bad, 0);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_fd",   nfd, 1);

    // Next frame clears overflow; reset mid-window
    cfg(1'b1, 0, 0, 40, 2, 8'h80);
    bus.in_vsync = 1'b1;
    repeat (3) tick();
    chk("ovf_clr", 32'(overflow), 0);
    for (int p = 0; p < 36; p++) begin
      bus.in_href = 1'b1;
      bus.in_data = 8'hFF;
      tick();
    end
    chk("mid_wr",   wa.size(), 1);
    chk("mid_addr", 32'(bus.ram_addr), 1);
    rst = 1'b1;
    tick();
    rst          = 1'b0;
    bus.in_href  = 1'b0;
    bus.in_vsync = 1'b0;
    bus.in_data  = 8'h00;
    chk("mrst_wen",   32'(bus.ram_wen),  0);
    chk("mrst_addr",  32'(bus.ram_addr), 0);
    chk("mrst_wdata", bus.ram_wdata,     0);
    chk("mrst_fd",    32'(frame_done),   0);
    chk("mrst_ovf",   32'(overflow),     0);
    repeat (6) tick();
    chk("mrst_nofd", nfd, 0);

    cfg(1'b1, 0, 0, 40, 2, 8'h80);
    frame(2, 40, 1);
    chk("post_n",  wa.size(), 4);
    chk("post_a0", 32'(wa[0]), 0);
    chk("post_d1", wd[1], 32'hFF000000);
    chk("post_a3", 32'(wa[3]), 3);
    chk("post_fd", nfd, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
